cr_write_sched: RTL

- Scheduler for the single synchronous write port of the capability register file (CR0..CR3).
- Shares that port between two requesters: A, the pipeline writeback, and B, the trap/debug unit.
- Also runs a multi-cycle revocation sweep that clears every CR tag, or zeroes every full record.
- Sits between the requesters and the CR file write-port inputs; all write-port outputs are registered.

---
 rtl/cr_write_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/cr_write_sched.sv
// Write-port scheduler for the capability register file: round-robin A/B arbitration plus a tag/record revocation sweep.
// Optional build macro CR_WR_LOCK_CR0_EN: requester A writes to CR0 are handshaken but suppressed and flagged on ow_a_err.
module cr_write_sched #(
  parameter  int ADDR_W   = 48,
  parameter  int DATA_W   = 24,
  parameter  int CR_IDX_W = 2,
  localparam int NUM_CR   = 1 << CR_IDX_W,
  localparam int REC_W    = 3*ADDR_W + 2*DATA_W + 1
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic                iw_a_valid,
  output logic                ow_a_ready,
  input  logic [CR_IDX_W-1:0] iw_a_addr,
  input  logic [5:0]          iw_a_mask,
  input  logic [REC_W-1:0]    iw_a_rec,
  input  logic                iw_b_valid,
  output logic                ow_b_ready,
  input  logic [CR_IDX_W-1:0] iw_b_addr,
  input  logic [5:0]          iw_b_mask,
  input  logic [REC_W-1:0]    iw_b_rec,
  input  logic                iw_sweep_req,
  input  logic                iw_sweep_mode,
  output logic                ow_sweep_busy,
  output logic                ow_sweep_done,
  output logic [CR_IDX_W-1:0] ow_write_addr,
  output logic                ow_write_en_base,
  output logic                ow_write_en_len,
  output logic                ow_write_en_cur,
  output logic                ow_write_en_perms,
  output logic                ow_write_en_attr,
  output logic                ow_write_en_tag,
  output logic [ADDR_W-1:0]   ow_write_base,
  output logic [ADDR_W-1:0]   ow_write_len,
  output logic [ADDR_W-1:0]   ow_write_cur,
  output logic [DATA_W-1:0]   ow_write_perms,
  output logic [DATA_W-1:0]   ow_write_attr,
  output logic                ow_write_tag,
  output logic                ow_a_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CR_IDX_W-1:0] IDX_LAST = CR_IDX_W'(NUM_CR - 1);
  localparam logic [CR_IDX_W-1:0] IDX_ONE  = CR_IDX_W'(1);
  localparam logic [5:0]          EN_ALL   = 6'b111111;
  localparam logic [5:0]          EN_TAG   = 6'b000001;

  state_t                state_r;
  logic                  rr_r;        // 0: A wins next contention, 1: B wins
  logic [CR_IDX_W-1:0]   idx_r;       // CR currently being written by the sweep
  logic                  mode_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic [CR_IDX_W-1:0]   addr_r;
  logic [5:0]            en_r;
  logic [ADDR_W-1:0]     base_r;
  logic [ADDR_W-1:0]     len_r;
  logic [ADDR_W-1:0]     cur_r;
  logic [DATA_W-1:0]     perms_r;
  logic [DATA_W-1:0]     attr_r;
  logic                  tag_r;

  logic                  accept_ok_s;
  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  a_xfer_s;
  logic                  b_xfer_s;
  logic                  contend_s;
  logic                  lock_s;
  logic [CR_IDX_W-1:0]   sel_addr_s;
  logic [5:0]            sel_mask_s;
  logic [REC_W-1:0]      sel_rec_s;

  // Arbitration and selection of the requester that transfers this cycle
  always_comb begin
    accept_ok_s = iw_rst_n && (state_r == ST_IDLE) && !iw_sweep_req;
    contend_s   = iw_a_valid && iw_b_valid;
    if (contend_s) begin
      grant_a_s = ~rr_r;
      grant_b_s = rr_r;
    end else begin
      grant_a_s = iw_a_valid;
      grant_b_s = iw_b_valid;
    end
    a_xfer_s = accept_ok_s && grant_a_s;
    b_xfer_s = accept_ok_s && grant_b_s;
    if (a_xfer_s) begin
      sel_addr_s = iw_a_addr;
      sel_mask_s = iw_a_mask;
      sel_rec_s  = iw_a_rec;
    end else begin
      sel_addr_s = iw_b_addr;
      sel_mask_s = iw_b_mask;
      sel_rec_s  = iw_b_rec;
    end
`ifdef CR_WR_LOCK_CR0_EN
    lock_s = a_xfer_s && (iw_a_addr == {CR_IDX_W{1'b0}});
`else
    lock_s = 1'b0;
`endif
  end

  assign ow_a_ready = a_xfer_s;
  assign ow_b_ready = b_xfer_s;

  // Scheduler FSM with all write-port outputs registered
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_r <= ST_IDLE;
      rr_r    <= 1'b0;
      idx_r   <= {CR_IDX_W{1'b0}};
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      addr_r  <= {CR_IDX_W{1'b0}};
      en_r    <= 6'b000000;
      base_r  <= {ADDR_W{1'b0}};
      len_r   <= {ADDR_W{1'b0}};
      cur_r   <= {ADDR_W{1'b0}};
      perms_r <= {DATA_W{1'b0}};
      attr_r  <= {DATA_W{1'b0}};
      tag_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (iw_sweep_req) begin
            // The first sweep write is issued straight from the request edge
            state_r <= ST_SWEEP;
            mode_r  <= iw_sweep_mode;
            busy_r  <= 1'b1;
            err_r   <= 1'b0;
            idx_r   <= {CR_IDX_W{1'b0}};
            addr_r  <= {CR_IDX_W{1'b0}};
            en_r    <= iw_sweep_mode ? EN_ALL : EN_TAG;
            base_r  <= {ADDR_W{1'b0}};
            len_r   <= {ADDR_W{1'b0}};
            cur_r   <= {ADDR_W{1'b0}};
            perms_r <= {DATA_W{1'b0}};
            attr_r  <= {DATA_W{1'b0}};
            tag_r   <= 1'b0;
          end else if (a_xfer_s || b_xfer_s) begin
            if (contend_s) begin
              rr_r <= ~rr_r;
            end else begin
              rr_r <= rr_r;
            end
            addr_r  <= sel_addr_s;
            en_r    <= lock_s ? 6'b000000 : sel_mask_s;
            err_r   <= lock_s;
            base_r  <= sel_rec_s[REC_W-1 -: ADDR_W];
            len_r   <= sel_rec_s[REC_W-1-ADDR_W -: ADDR_W];
            cur_r   <= sel_rec_s[REC_W-1-2*ADDR_W -: ADDR_W];
            perms_r <= sel_rec_s[2*DATA_W -: DATA_W];
            attr_r  <= sel_rec_s[DATA_W -: DATA_W];
            tag_r   <= sel_rec_s[0];
          end else begin
            en_r  <= 6'b000000;
            err_r <= 1'b0;
          end
        end
        ST_SWEEP: begin
          err_r <= 1'b0;
          if (idx_r == IDX_LAST) begin
            state_r <= ST_DONE;
            idx_r   <= {CR_IDX_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            en_r    <= 6'b000000;
          end else begin
            idx_r  <= idx_r + IDX_ONE;
            addr_r <= idx_r + IDX_ONE;
            en_r   <= mode_r ? EN_ALL : EN_TAG;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          err_r   <= 1'b0;
          en_r    <= 6'b000000;
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= {CR_IDX_W{1'b0}};
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          err_r   <= 1'b0;
          en_r    <= 6'b000000;
        end
      endcase
    end
  end

  assign ow_sweep_busy     = busy_r;
  assign ow_sweep_done     = done_r;
  assign ow_a_err          = err_r;
  assign ow_write_addr     = addr_r;
  assign ow_write_en_base  = en_r[5];
  assign ow_write_en_len   = en_r[4];
  assign ow_write_en_cur   = en_r[3];
  assign ow_write_en_perms = en_r[2];
  assign ow_write_en_attr  = en_r[1];
  assign ow_write_en_tag   = en_r[0];
  assign ow_write_base     = base_r;
  assign ow_write_len      = len_r;
  assign ow_write_cur      = cur_r;
  assign ow_write_perms    = perms_r;
  assign ow_write_attr     = attr_r;
  assign ow_write_tag      = tag_r;

endmodule
